// File: rtl/data_mem_responder_pkg.sv
// Shared constants for the data-memory responder: state encoding and data/address geometry.
package data_mem_responder_pkg;

  localparam int DATA_W     = 32;
  localparam int ADDR_SHIFT = 2;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE = 3'b001;
  localparam state_t ST_WAIT = 3'b010;
  localparam state_t ST_RESP = 3'b100;

endpackage

// File: rtl/dmem_array.sv
// Single-port word storage with synchronous write and registered read.
// The read register resets to zero; the storage itself is never reset.
module dmem_array
  import data_mem_responder_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    rdata <= '0;
    else if (re) rdata <= mem[idx];
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-port memory responder with programmable wait states and registered completion.
// Optional access counters are enabled by defining DMEM_ACCESS_CNT_EN.
//
//   state | meaning
//   IDLE  | ready to accept a read or write request
//   WAIT  | counting down wait states; inputs ignored
//   RESP  | array access happens on the edge entering this state
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       Address,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [DATA_W-1:0] Write_data,
  output logic [DATA_W-1:0] Read_data,
  output logic              mem_ready,
  output logic              mem_busy,
  output logic              mem_err,
  output logic [31:0]       rd_cnt,
  output logic [31:0]       wr_cnt,
  output logic [31:0]       err_cnt
);

  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t            state, state_nxt;
  logic [3:0]        wait_cnt;
  logic [ADDR_W-1:0] idx_q, cur_idx;
  logic [DATA_W-1:0] wdata_q, cur_wdata;
  logic              wr_q, err_q, cur_wr, cur_err;
  logic              req, req_err, arr_we, arr_re;

  assign req     = MemRead | MemWrite;
  assign req_err = (MemRead & MemWrite) | (Address[ADDR_SHIFT-1:0] != '0) |
                   ((Address >> (ADDR_W + ADDR_SHIFT)) != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (req) state_nxt = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
      ST_WAIT: if (wait_cnt == 4'd0) state_nxt = ST_RESP;
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // With zero wait states the access edge is also the acceptance edge, so use live inputs in IDLE.
  always_comb begin
    cur_idx   = idx_q;
    cur_wdata = wdata_q;
    cur_wr    = wr_q;
    cur_err   = err_q;
    if (state == ST_IDLE) begin
      cur_idx   = Address[ADDR_W+ADDR_SHIFT-1:ADDR_SHIFT];
      cur_wdata = Write_data;
      cur_wr    = MemWrite;
      cur_err   = req_err;
    end
    arr_we = (state_nxt == ST_RESP) && (state != ST_RESP) && cur_wr && !cur_err;
    arr_re = (state_nxt == ST_RESP) && (state != ST_RESP) && !cur_wr && !cur_err;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= '0;
      idx_q    <= '0;
      wdata_q  <= '0;
      wr_q     <= 1'b0;
      err_q    <= 1'b0;
    end else if (state == ST_IDLE && req) begin
      wait_cnt <= WAIT_LOAD;
      idx_q    <= Address[ADDR_W+ADDR_SHIFT-1:ADDR_SHIFT];
      wdata_q  <= Write_data;
      wr_q     <= MemWrite;
      err_q    <= req_err;
    end else if (state == ST_WAIT && wait_cnt != 4'd0) begin
      wait_cnt <= wait_cnt - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_ready <= 1'b0;
      mem_err   <= 1'b0;
    end else begin
      mem_ready <= (state == ST_RESP);
      mem_err   <= (state == ST_RESP) && err_q;
    end
  end

  assign mem_busy = (state != ST_IDLE) | mem_ready;

`ifdef DMEM_ACCESS_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_cnt  <= '0;
      wr_cnt  <= '0;
      err_cnt <= '0;
    end else if (state == ST_RESP) begin
      if (err_q)     err_cnt <= err_cnt + 32'd1;
      else if (wr_q) wr_cnt  <= wr_cnt + 32'd1;
      else           rd_cnt  <= rd_cnt + 32'd1;
    end
  end
`else
  assign rd_cnt  = '0;
  assign wr_cnt  = '0;
  assign err_cnt = '0;
`endif

  dmem_array #(.ADDR_W(ADDR_W)) u_array (
    .clk   (clk),
    .rst   (rst),
    .we    (arr_we),
    .re    (arr_re),
    .idx   (cur_idx),
    .wdata (cur_wdata),
    .rdata (Read_data)
  );

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Memory-side responder for the CPU data port: accepts single-word read/write requests driven on `Address`/`MemRead`/`MemWrite`/`Write_data`, serves them from an internal word array after a configurable number of wait states, and returns `Read_data` with a one-cycle `mem_ready` completion pulse. It sits between the multicycle CPU and the data-memory array and is the point where memory latency and stall behaviour are introduced into the system.

## Interface
Parameters:
- `ADDR_W`, default 10: word-address bits. The array holds 2^ADDR_W 32-bit words.
- `WAIT_CYCLES`, default 2: wait states between request acceptance and completion. Legal range is 0..15.

Ports:
- `clk`, input, 1: single clock. All state changes on the rising edge.
- `rst`, input, 1: reset, asynchronous, active-low. Asserted when 0.
- `Address`, input, 32: byte address from the requester.
- `MemRead`, input, 1: read request.
- `MemWrite`, input, 1: write request.
- `Write_data`, input, 32: store data.
- `Read_data`, output, 32: load data. Valid when `mem_ready`=1 for a read, then held.
- `mem_ready`, output, 1: one-cycle completion pulse for any accepted request, including errors.
- `mem_busy`, output, 1: high from the cycle after acceptance through the `mem_ready` cycle.
- `mem_err`, output, 1: qualifies `mem_ready`. 1 means the request was rejected and had no effect.
- `rd_cnt`, output, 32: completed reads.
- `wr_cnt`, output, 32: completed writes.
- `err_cnt`, output, 32: rejected requests.

## Operation
- FSM states are IDLE, WAIT and RESP. Reset state is IDLE.
- IDLE: a request is `MemRead | MemWrite`. On a request, latch `Address`, `Write_data` and the op into internal registers. The next state is WAIT, or RESP if `WAIT_CYCLES`=0. Inputs are ignored after acceptance.
- WAIT: a down-counter is loaded with `WAIT_CYCLES-1` at acceptance. The FSM moves to RESP when the counter reaches 0.
- RESP: `mem_ready`=1 for exactly one cycle, then return to IDLE. Requests are never accepted in RESP.
- Errors are evaluated at acceptance. Each error sets `mem_err`=1 in RESP, performs no array access, and leaves `Read_data` unchanged:
  - `MemRead` and `MemWrite` both high.
  - `Address[1:0]` != 0.
  - `Address[31:ADDR_W+2]` != 0.
- Word index is `Address[ADDR_W+1:2]`.
- Write commit: the array is written on the edge that enters RESP.
- Read data: `Read_data` is loaded from the array on the edge that enters RESP and holds until the next successful read.
- A read issued on the access right after a write to the same address returns the new data.
- Array contents are not reset. They are undefined until written.
- Counters increment on the edge leaving RESP: `rd_cnt`/`wr_cnt` for successful accesses, `err_cnt` for errors. All counters wrap from 2^32-1 to 0.

## Timing
- Reset values: `Read_data`=0, `mem_ready`=0, `mem_busy`=0, `mem_err`=0, all counters 0, FSM in IDLE.
- A request sampled at edge N gives `mem_ready`=1 in the cycle after edge N+1+`WAIT_CYCLES`.
- Back-to-back throughput is one access per `WAIT_CYCLES`+2 cycles, because IDLE must be re-entered before the next acceptance.
- Requester rule: hold the request until it sees `mem_ready`, then deassert it the following cycle or present a new request. A request still held in the first IDLE cycle after RESP is treated as a new access.
- `mem_ready` and `mem_err` are registered outputs. No combinational path exists from the request inputs.
- Reset mid-operation: the FSM returns to IDLE immediately. A pending write that has not yet reached its commit edge is dropped, and no counters change.

## Configuration
- `DMEM_ACCESS_CNT_EN` defined: `rd_cnt`, `wr_cnt` and `err_cnt` are implemented as above.
- `DMEM_ACCESS_CNT_EN` undefined: the counter registers are removed and all three ports are tied to 0. The ports stay present so the top-level wiring is unchanged.

## Structure
- Shared package holds:
  - FSM state encoding, one-hot, 3 bits, as named localparams.
  - `DATA_W`=32.
  - Byte-to-word address shift constant, 2.
- Sub-module `dmem_array`: 2^ADDR_W x 32 storage, with synchronous write enable and synchronous registered read, single port. The FSM drives its enable and index.
- The FSM, wait counter, request latches, error check and counters live in `data_mem_responder`.

## Test plan
- Basic write/read, `WAIT_CYCLES`=2: write 0xDEADBEEF to 0x40, then read 0x40. Expect `mem_ready` 4 cycles after each acceptance, `Read_data`=0xDEADBEEF, `mem_err`=0, `wr_cnt`=1, `rd_cnt`=1.
- Zero wait, `WAIT_CYCLES`=0: read held continuously at 0x0 and 0x4 alternating. Expect `mem_ready` every 2nd cycle.
- Errors:
  - Read of 0x3 gives `mem_ready`=1 with `mem_err`=1.
  - `MemRead`=`MemWrite`=1 gives the same error response.
  - With `ADDR_W`=10, address 0x1000 also gives the error response.
  - In all three cases `Read_data` is unchanged and `err_cnt`=3.
- Input change during WAIT: change `Address`/`Write_data` after acceptance. Expect the latched values to be used.
- Reset mid-write: assert `rst`=0 during WAIT of a write of 0x12345678 to 0x80. Expect all outputs 0 immediately. A subsequent write 0x1 then read 0x80 returns 0x1. `wr_cnt` counts only the post-reset write.
- Macro: with `DMEM_ACCESS_CNT_EN` undefined, run 5 accesses. Expect all counter ports to stay 0.
